// File: rtl/mem_pkg.sv
// Purpose: shared op codes, FSM states and byte-lane helpers for the MEM stage.
// Latency: n/a (types, constants and pure functions only).
// Backpressure: n/a.
package mem_pkg;

  // Memory op encodings carried down the pipeline from decode.
  localparam logic [3:0] MEM_NONE = 4'd0;
  localparam logic [3:0] MEM_LB   = 4'd1;
  localparam logic [3:0] MEM_LBU  = 4'd2;
  localparam logic [3:0] MEM_LH   = 4'd3;
  localparam logic [3:0] MEM_LHU  = 4'd4;
  localparam logic [3:0] MEM_LW   = 4'd5;
  localparam logic [3:0] MEM_SB   = 4'd6;
  localparam logic [3:0] MEM_SH   = 4'd7;
  localparam logic [3:0] MEM_SW   = 4'd8;

  // Big-endian lane map: byte offset 0 lives in bits 31:24 (be[3]).
  localparam logic [3:0] BE_BYTE0   = 4'b1000;
  localparam logic [3:0] BE_HALF_HI = 4'b1100;
  localparam logic [3:0] BE_HALF_LO = 4'b0011;
  localparam logic [3:0] BE_WORD    = 4'b1111;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_REQ  = 2'd1,
    S_DONE = 2'd2
  } state_e;

  function automatic logic is_mem_op(input logic [3:0] op);
    return (op >= MEM_LB) && (op <= MEM_SW);
  endfunction

  function automatic logic is_store_op(input logic [3:0] op);
    return (op >= MEM_SB) && (op <= MEM_SW);
  endfunction

  // Byte enables for an access; loads use the same lane mask as stores of equal size.
  function automatic logic [3:0] lane_mask(input logic [3:0] op, input logic [1:0] a);
    case (op)
      MEM_LB, MEM_LBU, MEM_SB: return BE_BYTE0 >> a;
      MEM_LH, MEM_LHU, MEM_SH: return a[1] ? BE_HALF_LO : BE_HALF_HI;
      default:                 return BE_WORD;
    endcase
  endfunction

  // Replicate the store source across every lane it could land in.
  function automatic logic [31:0] store_word(input logic [3:0] op, input logic [31:0] rt);
    case (op)
      MEM_SB:  return {4{rt[7:0]}};
      MEM_SH:  return {2{rt[15:0]}};
      default: return rt;
    endcase
  endfunction

endpackage

// File: rtl/mem_stage_if.sv
// Purpose: req/ack data-memory port between the MEM stage (master) and data memory (slave).
// Latency: ack may come any number of cycles after req; rdata is valid in the ack cycle.
// Backpressure: master holds req and all request fields stable until ack.
interface mem_stage_if #(
  parameter int ADDR_W = 32
);
  logic              req;
  logic              we;
  logic [ADDR_W-1:0] addr;
  logic [3:0]        be;
  logic [31:0]       wdata;
  logic              ack;
  logic [31:0]       rdata;

  modport master (output req, we, addr, be, wdata, input ack, rdata);
  modport slave  (input req, we, addr, be, wdata, output ack, rdata);
endinterface

// File: rtl/mem_load_ext.sv
// Purpose: selects the addressed byte/halfword of a big-endian read word and sign/zero-extends it.
// Latency: combinational.
// Backpressure: none.
module mem_load_ext
  import mem_pkg::*;
(
  input  logic [3:0]  op,
  input  logic [1:0]  lane,
  input  logic [31:0] word,
  output logic [31:0] data
);

  logic [7:0]  sel_b;
  logic [15:0] sel_h;

  // Lane select then extension according to the load flavour.
  always_comb begin
    sel_b = 8'h00;
    sel_h = 16'h0000;
    data  = word;
    case (lane)
      2'd0:    sel_b = word[31:24];
      2'd1:    sel_b = word[23:16];
      2'd2:    sel_b = word[15:8];
      default: sel_b = word[7:0];
    endcase
    sel_h = lane[1] ? word[15:0] : word[31:16];
    case (op)
      MEM_LB:  data = {{24{sel_b[7]}}, sel_b};
      MEM_LBU: data = {24'h0, sel_b};
      MEM_LH:  data = {{16{sel_h[15]}}, sel_h};
      MEM_LHU: data = {16'h0, sel_h};
      default: data = word;
    endcase
  end

endmodule

// File: rtl/mem_stage.sv
// Purpose: MEM pipeline stage; runs loads/stores on the dmem port, passes ALU results through.
// Latency: non-memory ops 0 cycles; memory ops 3 cycles minimum plus one per dmem wait cycle.
// Backpressure: stall_req_o holds upstream while an access is outstanding.
// Build option: MEM_ALIGN_CHECK_EN adds misalign_o and suppresses misaligned half/word accesses.
module mem_stage
  import mem_pkg::*;
#(
  parameter int ADDR_W     = 32,
  parameter int REG_ADDR_W = 5
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  ex_write_reg_en_i,
  input  logic [REG_ADDR_W-1:0] ex_write_reg_addr_i,
  input  logic [31:0]           ex_write_reg_data_i,
  input  logic [3:0]            mem_op_i,
  input  logic [ADDR_W-1:0]     mem_addr_i,
  input  logic [31:0]           mem_store_data_i,
  mem_stage_if.master           dmem,
  output logic                  stall_req_o,
  output logic                  mem_write_reg_en_o,
  output logic [REG_ADDR_W-1:0] mem_write_reg_addr_o,
  output logic [31:0]           mem_write_reg_data_o
`ifdef MEM_ALIGN_CHECK_EN
  ,
  output logic                  misalign_o
`endif
);

  state_e      state;
  logic [31:0] rdata_buf;
  logic [31:0] load_data;
  logic        mem_op;
  logic        misalign;
  logic        start;

  assign mem_op = is_mem_op(mem_op_i);

`ifdef MEM_ALIGN_CHECK_EN
  assign misalign = ((mem_op_i == MEM_LH || mem_op_i == MEM_LHU || mem_op_i == MEM_SH) && mem_addr_i[0])
                 || ((mem_op_i == MEM_LW || mem_op_i == MEM_SW) && (mem_addr_i[1:0] != 2'b00));
  assign misalign_o = !rst && (state == S_IDLE) && misalign;
`else
  assign misalign = 1'b0;
`endif

  assign start       = !rst && (state == S_IDLE) && mem_op && !misalign;
  assign stall_req_o = start || (!rst && state == S_REQ);

  mem_load_ext u_load_ext (
    .op   (mem_op_i),
    .lane (mem_addr_i[1:0]),
    .word (rdata_buf),
    .data (load_data)
  );

  // FSM with the registered dmem request bank and read-data buffer.
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= S_IDLE;
      dmem.req   <= 1'b0;
      dmem.we    <= 1'b0;
      dmem.addr  <= '0;
      dmem.be    <= 4'h0;
      dmem.wdata <= 32'h0;
      rdata_buf  <= 32'h0;
    end else begin
      case (state)
        S_IDLE: begin
          if (start) begin
            dmem.req   <= 1'b1;
            dmem.we    <= is_store_op(mem_op_i);
            dmem.addr  <= {mem_addr_i[ADDR_W-1:2], 2'b00};
            dmem.be    <= lane_mask(mem_op_i, mem_addr_i[1:0]);
            dmem.wdata <= store_word(mem_op_i, mem_store_data_i);
            state      <= S_REQ;
          end
        end
        S_REQ: begin
          if (dmem.ack) begin
            rdata_buf <= dmem.rdata;
            dmem.req  <= 1'b0;
            dmem.we   <= 1'b0;
            state     <= S_DONE;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  // Writeback mux: ALU pass-through in IDLE, extended load data in DONE, nothing otherwise.
  always_comb begin
    mem_write_reg_en_o   = 1'b0;
    mem_write_reg_addr_o = ex_write_reg_addr_i;
    mem_write_reg_data_o = ex_write_reg_data_i;
    if (!rst) begin
      if (state == S_IDLE && !mem_op) begin
        mem_write_reg_en_o = ex_write_reg_en_i;
      end else if (state == S_DONE && mem_op && !is_store_op(mem_op_i)) begin
        mem_write_reg_en_o   = ex_write_reg_en_i;
        mem_write_reg_data_o = load_data;
      end
    end
  end

endmodule

// File: tb/tb_mem_stage.sv
// Purpose: randomized scoreboard bench for mem_stage with a behavioural memory responder.
// Latency: checks retire latency, request duration and stall duration per instruction.
// Backpressure: responder inserts a per-access number of wait cycles before ack.
module tb_mem_stage;
  import mem_pkg::*;

  typedef struct {
    logic        we;
    logic [31:0] addr;
    logic [3:0]  be;
    logic [31:0] wdata;
  } req_exp_t;

  typedef struct {
    logic        en;
    logic [4:0]  addr;
    logic [31:0] data;
    logic        mis;
  } ret_exp_t;

  typedef struct {
    int          waits;
    logic [31:0] rdata;
  } resp_t;

  logic        clk = 1'b0;
  logic        rst;
  logic        ex_en;
  logic [4:0]  ex_waddr;
  logic [31:0] ex_wdata;
  logic [3:0]  op;
  logic [31:0] maddr;
  logic [31:0] rt;
  logic        stall;
  logic        wb_en;
  logic [4:0]  wb_addr;
  logic [31:0] wb_data;
  logic        mis_act;
  logic        resp_ack;
  logic        late_ack;
  logic [31:0] resp_rdata;

  req_exp_t req_q[$];
  ret_exp_t ret_q[$];
  resp_t    resp_q[$];

  int checks = 0;
  int failures = 0;
  logic monitor_on = 1'b0;
  logic req_prev = 1'b0;

  mem_stage_if #(.ADDR_W(32)) dmem ();
  assign dmem.ack   = resp_ack | late_ack;
  assign dmem.rdata = resp_rdata;

  mem_stage #(.ADDR_W(32), .REG_ADDR_W(5)) dut (
    .clk                  (clk),
    .rst                  (rst),
    .ex_write_reg_en_i    (ex_en),
    .ex_write_reg_addr_i  (ex_waddr),
    .ex_write_reg_data_i  (ex_wdata),
    .mem_op_i             (op),
    .mem_addr_i           (maddr),
    .mem_store_data_i     (rt),
    .dmem                 (dmem),
    .stall_req_o          (stall),
    .mem_write_reg_en_o   (wb_en),
    .mem_write_reg_addr_o (wb_addr),
    .mem_write_reg_data_o (wb_data)
`ifdef MEM_ALIGN_CHECK_EN
    ,
    .misalign_o           (mis_act)
`endif
  );

`ifndef MEM_ALIGN_CHECK_EN
  assign mis_act = 1'b0;
`endif

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  function automatic int op_size(input logic [3:0] o);
    if (o == MEM_LB || o == MEM_LBU || o == MEM_SB) return 1;
    if (o == MEM_LH || o == MEM_LHU || o == MEM_SH) return 2;
    return 4;
  endfunction

  function automatic logic [3:0] model_be(input logic [3:0] o, input logic [31:0] a);
    logic [3:0] be;
    int sz;
    int base;
    be = 4'h0;
    sz = op_size(o);
    base = int'(a[1:0]) & ~(sz - 1);
    for (int k = 0; k < sz; k++) be[3 - (base + k)] = 1'b1;
    return be;
  endfunction

  function automatic logic [31:0] model_wdata(input logic [3:0] o, input logic [31:0] v);
    logic [31:0] w;
    int sz;
    w = 32'h0;
    sz = op_size(o);
    for (int lane = 0; lane < 4; lane++) w[8*lane +: 8] = v[8*(lane % sz) +: 8];
    return w;
  endfunction

  function automatic logic [31:0] model_load(input logic [3:0] o, input logic [31:0] a, input logic [31:0] word);
    logic [31:0] t;
    int sz;
    int base;
    sz = op_size(o);
    base = int'(a[1:0]) & ~(sz - 1);
    t = word >> (8 * (4 - sz - base));
    case (o)
      MEM_LB:  return 32'($signed(t[7:0]));
      MEM_LBU: return {24'h0, t[7:0]};
      MEM_LH:  return 32'($signed(t[15:0]));
      MEM_LHU: return {16'h0, t[15:0]};
      default: return word;
    endcase
  endfunction

  function automatic logic model_misalign(input logic [3:0] o, input logic [31:0] a);
`ifdef MEM_ALIGN_CHECK_EN
    if (o >= MEM_LB && o <= MEM_SW) return (int'(a[1:0]) % op_size(o)) != 0;
    return 1'b0;
`else
    return 1'b0;
`endif
  endfunction

  // Issue one instruction, queue its expectations, hold it until it retires.
  task automatic issue(input logic [3:0] o, input logic [31:0] a, input logic [31:0] src,
                       input logic [31:0] alu, input logic en, input logic [4:0] wa,
                       input int waits, input logic [31:0] rd);
    logic is_mem;
    logic is_st;
    logic mis;
    int exp_cyc;
    int exp_req;
    int n;
    int reqc;
    int stallc;
    ret_exp_t r;
    is_mem = (o >= MEM_LB) && (o <= MEM_SW);
    is_st  = (o >= MEM_SB) && (o <= MEM_SW);
    mis    = model_misalign(o, a);
    r.addr = wa;
    r.mis  = mis;
    r.data = alu;
    r.en   = en;
    if (is_mem && !mis) begin
      req_q.push_back('{is_st, {a[31:2], 2'b00}, model_be(o, a), model_wdata(o, src)});
      resp_q.push_back('{waits, rd});
      exp_cyc = waits + 3;
      exp_req = waits + 1;
      r.en    = is_st ? 1'b0 : en;
      r.data  = model_load(o, a, rd);
    end else begin
      exp_cyc = 1;
      exp_req = 0;
      if (is_mem) r.en = 1'b0;
    end
    ret_q.push_back(r);
    op = o; maddr = a; rt = src; ex_wdata = alu; ex_en = en; ex_waddr = wa;
    n = 0; reqc = 0; stallc = 0;
    do begin
      @(negedge clk);
      n++;
      if (dmem.req) reqc++;
      if (stall) stallc++;
    end while (stall && n < exp_cyc + 8);
    chk("latency", n, exp_cyc);
    chk("req_cycles", reqc, exp_req);
    chk("stall_cycles", stallc, exp_cyc - 1);
    @(posedge clk);
    #1;
  endtask

  // Memory responder: acks each request after its scripted number of wait cycles.
  initial begin : responder
    resp_t cur;
    logic  have;
    int    cnt;
    have = 1'b0;
    cnt = 0;
    cur = '{0, 32'h0};
    resp_ack = 1'b0;
    resp_rdata = 32'h0;
    forever begin
      @(posedge clk);
      #1;
      resp_ack = 1'b0;
      resp_rdata = $urandom;
      if (dmem.req) begin
        if (!have && resp_q.size() > 0) begin
          cur = resp_q.pop_front();
          have = 1'b1;
          cnt = 0;
        end
        if (have) begin
          if (cnt == cur.waits) begin
            resp_ack = 1'b1;
            resp_rdata = cur.rdata;
            have = 1'b0;
          end else begin
            cnt++;
          end
        end
      end else begin
        have = 1'b0;
      end
    end
  end

  // Monitor: compares each new request and each retired instruction against the queues.
  always @(negedge clk) begin
    if (monitor_on && !rst) begin
      if (dmem.req && !req_prev) begin
        if (req_q.size() == 0) begin
          chk("unexpected_req", 32'd1, 32'd0);
        end else begin
          req_exp_t e;
          e = req_q.pop_front();
          chk("req_we", 32'(dmem.we), 32'(e.we));
          chk("req_addr", dmem.addr, e.addr);
          chk("req_be", 32'(dmem.be), 32'(e.be));
          if (e.we) chk("req_wdata", dmem.wdata, e.wdata);
        end
      end
      if (!stall) begin
        if (ret_q.size() == 0) begin
          chk("unexpected_retire", 32'd1, 32'd0);
        end else begin
          ret_exp_t e;
          e = ret_q.pop_front();
          chk("wb_en", 32'(wb_en), 32'(e.en));
          if (e.en) begin
            chk("wb_addr", 32'(wb_addr), 32'(e.addr));
            chk("wb_data", wb_data, e.data);
          end
`ifdef MEM_ALIGN_CHECK_EN
          chk("misalign", 32'(mis_act), 32'(e.mis));
`endif
        end
      end
    end
    req_prev = dmem.req;
  end

  initial begin : driver
    rst = 1'b1; late_ack = 1'b0;
    ex_en = 1'b0; ex_waddr = 5'd0; ex_wdata = 32'h0; op = MEM_NONE; maddr = 32'h0; rt = 32'h0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_req", 32'(dmem.req), 32'd0);
    chk("rst_we", 32'(dmem.we), 32'd0);
    chk("rst_addr", dmem.addr, 32'h0);
    chk("rst_be", 32'(dmem.be), 32'd0);
    chk("rst_stall", 32'(stall), 32'd0);
    rst = 1'b0;
    monitor_on = 1'b1;

    // Directed cases.
    issue(MEM_NONE, 32'h0, 32'h0, 32'h1234, 1'b1, 5'd3, 0, 32'h0);
    issue(MEM_LW, 32'h100, 32'h0, 32'h0, 1'b1, 5'd4, 2, 32'hDEADBEEF);
    issue(MEM_LB, 32'h103, 32'h0, 32'h0, 1'b1, 5'd5, 0, 32'h000000F0);
    issue(MEM_LBU, 32'h103, 32'h0, 32'h0, 1'b1, 5'd6, 1, 32'h000000F0);
    issue(MEM_LH, 32'h102, 32'h0, 32'h0, 1'b1, 5'd7, 0, 32'h00008001);
    issue(MEM_SB, 32'h101, 32'hAB, 32'h0, 1'b1, 5'd8, 0, 32'h0);
    issue(MEM_SH, 32'h202, 32'h1234CDEF, 32'h0, 1'b1, 5'd9, 3, 32'h0);
    issue(MEM_LW, 32'h102, 32'h0, 32'h55, 1'b1, 5'd10, 0, 32'hCAFEF00D);
    issue(MEM_NONE, 32'h0, 32'h0, 32'h77, 1'b1, 5'd0, 0, 32'h0);

    // Reset while a load is waiting in REQ; the later ack must be ignored.
    req_q.push_back('{1'b0, 32'h300, 4'hF, 32'h0});
    resp_q.push_back('{20, 32'h11111111});
    op = MEM_LW; maddr = 32'h300; ex_en = 1'b1; ex_waddr = 5'd2;
    @(posedge clk); @(posedge clk);
    #1;
    rst = 1'b1; op = MEM_NONE; ex_en = 1'b0;
    @(posedge clk);
    #1;
    rst = 1'b0;
    late_ack = 1'b1;
    issue(MEM_NONE, 32'h0, 32'h0, 32'h99, 1'b0, 5'd2, 0, 32'h0);
    late_ack = 1'b0;
    issue(MEM_NONE, 32'h0, 32'h0, 32'h98, 1'b1, 5'd2, 0, 32'h0);

    // Randomized instruction stream.
    for (int i = 0; i < 300; i++) begin
      issue(4'($urandom_range(0, 8)), $urandom, $urandom, $urandom, 1'($urandom),
            5'($urandom), $urandom_range(0, 3), $urandom);
    end

    monitor_on = 1'b0;
    chk("req_q_empty", 32'(req_q.size()), 32'd0);
    chk("ret_q_empty", 32'(ret_q.size()), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
